// File: rtl/slsu_pkg.sv
// slsu_pkg: shared types and helpers for the load/store unit.
//   state_t   - controller states (IDLE, ACCESS, SPLIT, RESP)
//   SIZE_*    - encodings of the 2-bit access size field
//   nbytes()  - number of bytes moved for a given size encoding
package slsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        SPLIT  = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // 2'b11 is treated as a word, same as 2'b10.
    function automatic logic [2:0] nbytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/slsu_if.sv
// Interfaces of the load/store unit.
//
// slsu_req_if: request/response channel between the pipeline and the LSU.
//   Handshake: a request transfers on a rising clk edge where both
//   req_valid_i and req_ready_o are 1. The requester keeps all req_* fields
//   stable while req_valid_i is high and not yet accepted. The response is a
//   single-cycle strobe (resp_valid_o) with no backpressure; the consumer
//   must take it in that cycle.
//   modport master - pipeline side, modport slave - LSU side.
//
// slsu_mem_if: LSU to data-memory bus. Memory read data is combinational
//   and already sign-extended by the memory to mem_size_o.
//   modport master - LSU side, modport slave - memory side.
interface slsu_req_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_load_i;
    logic                  req_store_i;
    logic [1:0]            req_size_i;
    logic                  req_unsigned_i;
    logic [DATA_WIDTH-1:0] req_base_i;
    logic [DATA_WIDTH-1:0] req_offset_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic [4:0]            req_rd_i;
    logic                  resp_valid_o;
    logic [4:0]            resp_rd_o;
    logic [DATA_WIDTH-1:0] resp_data_o;
    logic                  resp_err_o;

    modport master (
        output req_valid_i, req_load_i, req_store_i, req_size_i, req_unsigned_i,
               req_base_i, req_offset_i, req_wdata_i, req_rd_i,
        input  req_ready_o, resp_valid_o, resp_rd_o, resp_data_o, resp_err_o
    );

    modport slave (
        input  req_valid_i, req_load_i, req_store_i, req_size_i, req_unsigned_i,
               req_base_i, req_offset_i, req_wdata_i, req_rd_i,
        output req_ready_o, resp_valid_o, resp_rd_o, resp_data_o, resp_err_o
    );
endinterface

interface slsu_mem_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  mem_read_o;
    logic                  mem_write_o;
    logic [1:0]            mem_size_o;
    logic [DATA_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport master (
        output mem_read_o, mem_write_o, mem_size_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_read_o, mem_write_o, mem_size_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/slsu_extend.sv
// slsu_extend: combinational load-data extender.
//   size - access size (byte/half/word)
//   uns  - 1: zero-extend, 0: sign-extend
//   raw  - assembled or captured load data, valid in its low nbytes
//   ext  - extended result
module slsu_extend
    import slsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            size,
    input  logic                  uns,
    input  logic [DATA_WIDTH-1:0] raw,
    output logic [DATA_WIDTH-1:0] ext
);
    logic sign_b;
    logic sign_h;

    assign sign_b = ~uns & raw[7];
    assign sign_h = ~uns & raw[15];

    always_comb begin
        ext = raw;
        case (size)
            SIZE_BYTE: ext = {{(DATA_WIDTH-8){sign_b}}, raw[7:0]};
            SIZE_HALF: ext = {{(DATA_WIDTH-16){sign_h}}, raw[15:0]};
            default:   ext = raw;
        endcase
    end
endmodule

// File: rtl/slsu.sv
// slsu: load/store unit in front of the data memory.
//   clk, rst  - clock, synchronous active-high reset
//   req       - request/response channel (slsu_req_if.slave)
//   mem       - data memory bus (slsu_mem_if.master)
//   dbg_state - current controller state, for observation only
// Accepts one request at a time, bounds-checks the effective address,
// performs an aligned access in one cycle or a misaligned access as a
// sequence of byte accesses, then emits a single-cycle response.
module slsu
    import slsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 1024
) (
    input  logic       clk,
    input  logic       rst,
    slsu_req_if.slave  req,
    slsu_mem_if.master mem,
    output state_t     dbg_state
);
    localparam int AW = DATA_WIDTH + 1;
    localparam logic [AW-1:0] LAST_LEGAL = AW'(MEM_SIZE - 4);

    state_t state_q, state_d;

    // Request decode, evaluated on the incoming fields.
    logic                  accept;
    logic [DATA_WIDTH-1:0] ea_in;
    logic [2:0]            nb_in;
    logic                  misal_in;
    logic [AW-1:0]         last_in;
    logic                  oob_in;
    logic                  err_in;
    logic                  noop_in;

    // Registered request.
    logic                  load_q;
    logic                  store_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [DATA_WIDTH-1:0] ea_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [4:0]            rd_q;
    logic                  err_q;
    logic [2:0]            nb_q;
    logic [1:0]            cnt_q;
    logic [DATA_WIDTH-1:0] raw_q;
    logic [DATA_WIDTH-1:0] ext_data;

    assign accept   = req.req_valid_i && (state_q == IDLE);
    assign ea_in    = req.req_base_i + req.req_offset_i;
    assign nb_in    = nbytes(req.req_size_i);
    assign misal_in = ((req.req_size_i == SIZE_HALF) && ea_in[0]) ||
                      (req.req_size_i[1] && (ea_in[1:0] != 2'b00));
    // One extra bit so an address near 2^32 cannot wrap into range.
    assign last_in  = {1'b0, ea_in} + AW'(nb_in) - AW'(1);
    assign oob_in   = misal_in ? (last_in > LAST_LEGAL)
                               : ({1'b0, ea_in} > LAST_LEGAL);
    assign noop_in  = !req.req_load_i && !req.req_store_i;
    assign err_in   = (req.req_load_i && req.req_store_i) ||
                      (!noop_in && oob_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_q  <= 1'b0;
            store_q <= 1'b0;
            size_q  <= SIZE_BYTE;
            uns_q   <= 1'b0;
            ea_q    <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            nb_q    <= 3'd1;
            cnt_q   <= 2'd0;
            raw_q   <= '0;
        end else begin
            if (accept) begin
                load_q  <= req.req_load_i;
                store_q <= req.req_store_i;
                size_q  <= req.req_size_i;
                uns_q   <= req.req_unsigned_i;
                ea_q    <= ea_in;
                wdata_q <= req.req_wdata_i;
                rd_q    <= req.req_rd_i;
                err_q   <= err_in;
                nb_q    <= nb_in;
                cnt_q   <= 2'd0;
                raw_q   <= '0;
            end
            if (state_q == ACCESS && load_q) begin
                raw_q <= mem.mem_rdata_i;
            end
            if (state_q == SPLIT) begin
                if (load_q) begin
                    raw_q[{cnt_q, 3'b000} +: 8] <= mem.mem_rdata_i[7:0];
                end
                cnt_q <= cnt_q + 2'd1;
            end
        end
    end

    slsu_extend #(.DATA_WIDTH(DATA_WIDTH)) u_extend (
        .size (size_q),
        .uns  (uns_q),
        .raw  (raw_q),
        .ext  (ext_data)
    );

    always_comb begin
        state_d          = state_q;
        req.req_ready_o  = 1'b0;
        req.resp_valid_o = 1'b0;
        req.resp_rd_o    = '0;
        req.resp_data_o  = '0;
        req.resp_err_o   = 1'b0;
        mem.mem_read_o   = 1'b0;
        mem.mem_write_o  = 1'b0;
        mem.mem_size_o   = SIZE_BYTE;
        mem.mem_addr_o   = '0;
        mem.mem_wdata_o  = '0;

        case (state_q)
            IDLE: begin
                req.req_ready_o = 1'b1;
                if (accept) begin
                    if (err_in || noop_in) begin
                        state_d = RESP;
                    end else if (!misal_in) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = SPLIT;
                    end
                end
            end
            ACCESS: begin
                mem.mem_read_o  = load_q;
                mem.mem_write_o = store_q;
                mem.mem_size_o  = size_q;
                mem.mem_addr_o  = ea_q;
                mem.mem_wdata_o = wdata_q;
                state_d         = RESP;
            end
            SPLIT: begin
                mem.mem_read_o  = load_q;
                mem.mem_write_o = store_q;
                mem.mem_size_o  = SIZE_BYTE;
                mem.mem_addr_o  = ea_q + DATA_WIDTH'(cnt_q);
                mem.mem_wdata_o = {{(DATA_WIDTH-8){1'b0}}, wdata_q[{cnt_q, 3'b000} +: 8]};
                if ({1'b0, cnt_q} == (nb_q - 3'd1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                req.resp_valid_o = 1'b1;
                req.resp_err_o   = err_q;
                // Only a successful load returns a register and data.
                if (load_q && !err_q) begin
                    req.resp_rd_o   = rd_q;
                    req.resp_data_o = ext_data;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dbg_state = state_q;
endmodule
